// File: rtl/msu_fetch_arbiter.sv
// rtl/msu_fetch_arbiter.sv - shares one 16-bit storage read port between the MSU data-track reader and audio fetcher
module msu_fetch_arbiter (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] data_addr,
  input  logic        data_seek,
  input  logic        data_req,
  output logic [7:0]  data,
  output logic        data_ack,
  input  logic        audio_req,
  input  logic [31:0] audio_addr,
  output logic [15:0] audio_data,
  output logic        audio_ack,
  output logic        audio_overrun,
  output logic [30:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [15:0] mem_dout
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_D, ST_WAIT_A} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;   // 0 = data, 1 = audio
  logic        d_pend_q, d_pend_d;
  logic        d_seek_q, d_seek_d;
  logic        a_pend_q, a_pend_d;
  logic        stale_q, stale_d;
  logic        cache_valid_q, cache_valid_d;
  logic [30:0] cache_tag_q, cache_tag_d;
  logic [15:0] cache_word_q, cache_word_d;
  logic [30:0] a_addr_q, a_addr_d;
  logic        seek_prev_q;
  logic [31:0] addr_prev_q;
  logic [7:0]  data_q, data_d;
  logic        data_ack_q, data_ack_d;
  logic [15:0] audio_data_q, audio_data_d;
  logic        audio_ack_q, audio_ack_d;
  logic        overrun_q, overrun_d;
  logic [30:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_q, mem_rd_d;

  logic        seek_ev, hit, miss, d_eff, a_eff, audio_done, grant_audio;
  logic        unused_audio_lsb;

  assign unused_audio_lsb = audio_addr[0];

  // A seek is a rising edge of data_seek or an address change while it is held.
  assign seek_ev    = data_seek && (!seek_prev_q || (data_addr != addr_prev_q));
  assign hit        = data_req && !seek_ev && cache_valid_q && (cache_tag_q == data_addr[31:1]);
  assign miss       = data_req && !seek_ev && !hit;
  assign d_eff      = d_pend_q || seek_ev || miss;
  assign a_eff      = a_pend_q || audio_req;
  assign audio_done = (state_q == ST_WAIT_A) && mem_ready;
  assign grant_audio = a_eff && (!d_eff || !last_grant_q);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    d_pend_d      = d_eff;
    d_seek_d      = d_seek_q || seek_ev;
    a_pend_d      = a_eff;
    stale_d       = stale_q || ((state_q == ST_WAIT_D) && seek_ev);
    cache_valid_d = cache_valid_q && !seek_ev;
    cache_tag_d   = cache_tag_q;
    cache_word_d  = cache_word_q;
    a_addr_d      = audio_req ? audio_addr[31:1] : a_addr_q;
    data_d        = data_q;
    data_ack_d    = 1'b0;
    audio_data_d  = audio_data_q;
    audio_ack_d   = 1'b0;
    overrun_d     = audio_req && a_pend_q && !audio_done;
    mem_addr_d    = mem_addr_q;
    mem_rd_d      = 1'b0;

    if (hit) begin
      data_d = data_addr[0] ? cache_word_q[15:8] : cache_word_q[7:0];
    end

    case (state_q)
      ST_IDLE: begin
        if (d_eff || a_eff) begin
          mem_rd_d = 1'b1;
          if (grant_audio) begin
            mem_addr_d   = audio_req ? audio_addr[31:1] : a_addr_q;
            last_grant_d = 1'b1;
            state_d      = ST_WAIT_A;
          end else begin
            mem_addr_d   = data_addr[31:1];
            last_grant_d = 1'b0;
            stale_d      = 1'b0;
            state_d      = ST_WAIT_D;
          end
        end
      end
      ST_WAIT_D: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
          stale_d = 1'b0;
          // A seek landing on the return cycle makes the word stale as well.
          if (!stale_q && !seek_ev) begin
            cache_valid_d = 1'b1;
            cache_tag_d   = mem_addr_q;
            cache_word_d  = mem_dout;
            if (mem_addr_q == data_addr[31:1]) begin
              data_d   = data_addr[0] ? mem_dout[15:8] : mem_dout[7:0];
              d_pend_d = 1'b0;
              if (d_seek_q) begin
                data_ack_d = 1'b1;
                d_seek_d   = 1'b0;
              end
            end
          end
        end
      end
      ST_WAIT_A: begin
        if (mem_ready) begin
          audio_data_d = mem_dout;
          audio_ack_d  = 1'b1;
          a_pend_d     = audio_req;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b0;
      d_pend_q      <= 1'b0;
      d_seek_q      <= 1'b0;
      a_pend_q      <= 1'b0;
      stale_q       <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_word_q  <= '0;
      a_addr_q      <= '0;
      seek_prev_q   <= 1'b0;
      addr_prev_q   <= '0;
      data_q        <= '0;
      data_ack_q    <= 1'b0;
      audio_data_q  <= '0;
      audio_ack_q   <= 1'b0;
      overrun_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_rd_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      d_pend_q      <= d_pend_d;
      d_seek_q      <= d_seek_d;
      a_pend_q      <= a_pend_d;
      stale_q       <= stale_d;
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_word_q  <= cache_word_d;
      a_addr_q      <= a_addr_d;
      seek_prev_q   <= data_seek;
      addr_prev_q   <= data_addr;
      data_q        <= data_d;
      data_ack_q    <= data_ack_d;
      audio_data_q  <= audio_data_d;
      audio_ack_q   <= audio_ack_d;
      overrun_q     <= overrun_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_q      <= mem_rd_d;
    end
  end

  assign data          = data_q;
  assign data_ack      = data_ack_q;
  assign audio_data    = audio_data_q;
  assign audio_ack     = audio_ack_q;
  assign audio_overrun = overrun_q;
  assign mem_addr      = mem_addr_q;
  assign mem_rd        = mem_rd_q;

endmodule

// File: tb/tb_msu_fetch_arbiter.sv
// tb/tb_msu_fetch_arbiter.sv - scoreboard bench for msu_fetch_arbiter
module tb_msu_fetch_arbiter;

  localparam int MEM_LAT = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] data_addr = '0;
  logic        data_seek = 1'b0;
  logic        data_req = 1'b0;
  logic [7:0]  data;
  logic        data_ack;
  logic        audio_req = 1'b0;
  logic [31:0] audio_addr = '0;
  logic [15:0] audio_data;
  logic        audio_ack;
  logic        audio_overrun;
  logic [30:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_dout = '0;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0, dack_cnt = 0, aack_cnt = 0, ovr_cnt = 0;
  int resp_cnt = 0;
  logic [30:0] resp_addr = '0;

  logic [31:0] exp_rd[$];
  logic [31:0] exp_dack[$];
  logic [31:0] exp_audio[$];

  msu_fetch_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .data_addr(data_addr), .data_seek(data_seek), .data_req(data_req),
    .data(data), .data_ack(data_ack),
    .audio_req(audio_req), .audio_addr(audio_addr),
    .audio_data(audio_data), .audio_ack(audio_ack), .audio_overrun(audio_overrun),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready), .mem_dout(mem_dout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [30:0] a);
    if (a == 31'h091A) return 16'hBEEF;
    return {a[7:0] ^ 8'hA5, a[7:0] + 8'h11};
  endfunction

  // Storage model plus output monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    mem_ready = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        mem_ready = 1'b1;
        mem_dout  = mem_word(resp_addr);
      end
    end
    if (mem_rd) begin
      rd_cnt++;
      if (exp_rd.size() == 0) chk("rd_unexpected", exp_rd.size(), 1);
      else chk("rd_addr", {1'b0, mem_addr}, exp_rd.pop_front());
      resp_addr = mem_addr;
      resp_cnt  = MEM_LAT;
    end
    if (data_ack) begin
      dack_cnt++;
      chk("dack_no_rd", mem_rd, 0);
      if (exp_dack.size() == 0) chk("dack_unexpected", exp_dack.size(), 1);
      else chk("dack_data", data, exp_dack.pop_front());
    end
    if (audio_ack) begin
      aack_cnt++;
      chk("aack_no_rd", mem_rd, 0);
      if (exp_audio.size() == 0) chk("aack_unexpected", exp_audio.size(), 1);
      else chk("aack_data", audio_data, exp_audio.pop_front());
    end
    if (audio_overrun) ovr_cnt++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_rd.size() != 0 || exp_dack.size() != 0 || exp_audio.size() != 0 || resp_cnt != 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("drain_timeout", n, 0);
    repeat (3) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_dack"}, data_ack, 0);
    chk({tag, "_adata"}, audio_data, 0);
    chk({tag, "_aack"}, audio_ack, 0);
    chk({tag, "_ovr"}, audio_overrun, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mrd"}, mem_rd, 0);
  endtask

  initial begin
    int rd0, dk0, ak0, ov0, n;
    repeat (3) tick();
    check_outputs_zero("reset");
    RST_N = 1'b1;
    tick();

    // Seek fill to odd byte address.
    data_addr = 32'h0000_1235; data_seek = 1'b1;
    exp_rd.push_back(32'h091A); exp_dack.push_back(32'hBE);
    dk0 = dack_cnt;
    tick();
    drain();
    chk("seek_acks", dack_cnt - dk0, 1);
    data_seek = 1'b0;
    tick();

    // Sequential miss then hit.
    data_addr = 32'h1236; data_req = 1'b1;
    exp_rd.push_back(32'h091B);
    tick(); data_req = 1'b0;
    drain();
    chk("seq_miss_data", data, 8'h2C);
    rd0 = rd_cnt;
    data_addr = 32'h1237; data_req = 1'b1;
    tick(); data_req = 1'b0;
    chk("seq_hit_data", data, 8'hBE);
    repeat (4) tick();
    chk("seq_hit_no_rd", rd_cnt - rd0, 0);

    // Round-robin: both pending, last grant was data, so audio first.
    data_addr = 32'h3002; data_req = 1'b1;
    audio_addr = 32'h100; audio_req = 1'b1;
    exp_rd.push_back(32'h0080); exp_rd.push_back(32'h1801);
    exp_audio.push_back(32'h2591);
    ak0 = aack_cnt;
    tick(); data_req = 1'b0; audio_req = 1'b0;
    n = 0;
    while (aack_cnt == ak0 && n < 60) begin tick(); n++; end
    chk("rr_aack_seen", aack_cnt - ak0, 1);
    chk("rr_data_before", data, 8'hBE);
    drain();
    chk("rr_data_after", data, 8'h12);

    // Re-seek while a data fetch is in flight.
    data_addr = 32'h1236; data_req = 1'b1;
    exp_rd.push_back(32'h091B);
    rd0 = rd_cnt; dk0 = dack_cnt;
    tick(); data_req = 1'b0;
    tick();
    data_addr = 32'h4000; data_seek = 1'b1;
    exp_rd.push_back(32'h2000); exp_dack.push_back(32'h11);
    tick();
    drain();
    chk("reseek_rds", rd_cnt - rd0, 2);
    chk("reseek_acks", dack_cnt - dk0, 1);
    chk("reseek_data", data, 8'h11);
    data_seek = 1'b0;
    tick();

    // Overrun while data fetch busy.
    data_addr = 32'h5002; data_req = 1'b1;
    exp_rd.push_back(32'h2801); exp_rd.push_back(32'h0010);
    exp_audio.push_back(32'hB521);
    ak0 = aack_cnt; ov0 = ovr_cnt;
    tick(); data_req = 1'b0;
    audio_addr = 32'h10; audio_req = 1'b1;
    tick();
    audio_addr = 32'h20;
    tick(); audio_req = 1'b0;
    drain();
    chk("ovr_pulses", ovr_cnt - ov0, 1);
    chk("ovr_aacks", aack_cnt - ak0, 1);
    chk("ovr_data", data, 8'h12);

    // Reset while waiting for data; the late return must be ignored.
    data_addr = 32'h6000; data_req = 1'b1;
    exp_rd.push_back(32'h3000);
    tick(); data_req = 1'b0;
    RST_N = 1'b0;
    tick();
    check_outputs_zero("midrst");
    RST_N = 1'b1;
    rd0 = rd_cnt; dk0 = dack_cnt;
    repeat (8) tick();
    chk("midrst_no_rd", rd_cnt - rd0, 0);
    chk("midrst_no_ack", dack_cnt - dk0, 0);
    chk("midrst_data", data, 0);

    // Address wrap 0xFFFF_FFFF -> 0 is an ordinary miss.
    data_addr = 32'hFFFF_FFFF; data_seek = 1'b1;
    exp_rd.push_back(32'h7FFF_FFFF); exp_dack.push_back(32'h5A);
    tick();
    drain();
    data_seek = 1'b0;
    tick();
    data_addr = 32'h0; data_req = 1'b1;
    exp_rd.push_back(32'h0);
    tick(); data_req = 1'b0;
    drain();
    chk("wrap_data", data, 8'h11);

    chk("queues_empty", exp_rd.size() + exp_dack.size() + exp_audio.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msu_fetch_arbiter.md
# msu_fetch_arbiter

Shares a single 16-bit storage read port between the two MSU-1 streaming consumers: the data-track byte reader (the `data_seek`/`data_req`/`data_addr` handshake from the MSU register block) and the audio sample fetcher (word requests from the audio player). It holds a one-word data cache so sequential byte reads only touch memory every second byte. It arbitrates between the two consumers round-robin with a single outstanding memory read. The block sits between the MSU register block / audio player and the SDRAM/host-storage read adapter.

## Interface
- No parameters.
- CLK  in  1  system clock; single clock domain.
- RST_N  in  1  reset, synchronous, active-low.
- data_addr  in  32  byte address of the data-track stream.
- data_seek  in  1  level; high while a seek is outstanding.
- data_req  in  1  1-cycle pulse; `data_addr` advanced, next byte needed.
- data  out  8  current data-track byte.
- data_ack  out  1  1-cycle pulse; seek fill complete.
- audio_req  in  1  1-cycle pulse; fetch the word at `audio_addr`.
- audio_addr  in  32  byte address; bit 0 ignored.
- audio_data  out  16  returned sample word.
- audio_ack  out  1  1-cycle pulse; `audio_data` valid.
- audio_overrun  out  1  1-cycle pulse; `audio_req` arrived while an audio request was still pending.
- mem_addr  out  31  word address (byte address [31:1]).
- mem_rd  out  1  1-cycle read strike.
- mem_ready  in  1  1-cycle pulse; `mem_dout` valid.
- mem_dout  in  16  read word; byte at even address in [7:0], odd address in [15:8].

## Operation
- Reset values:
  - All outputs are 0.
  - Cache is invalid, `last_grant` = DATA, and the state machine is in IDLE.
  - Both pending flags are cleared.
- Pending flags:
  - **d_pend** is set by:
    - the rising edge of `data_seek`;
    - `data_seek` high while `data_addr` differs from its previous-cycle value (a re-seek);
    - a `data_req` miss.
  - A seek also sets **d_seek**, invalidates the cache, and marks any in-flight data fetch stale.
  - **a_pend** is set by `audio_req`, which latches `audio_addr[31:1]`. If `audio_req` arrives while a_pend is already set, the address is overwritten and `audio_overrun` pulses. An in-flight audio fetch is not affected.
- data_req hit: if the cache is valid and its tag equals `data_addr[31:1]`, `data` is updated from the cache using `data_addr[0]`; no memory access. A miss sets d_pend.
- FSM states:
  - IDLE:
    - If only one flag is pending, grant that requester.
    - If both are pending, grant the requester opposite to `last_grant`.
    - On a grant, drive `mem_addr`, pulse `mem_rd`, set `last_grant`, and move to WAIT_D or WAIT_A.
  - WAIT_D, on `mem_ready`:
    - If the fetch is stale, discard it; d_pend stays set.
    - Otherwise write the cache (word and tag), update `data` by `data_addr[0]`, and clear d_pend.
    - If d_seek was set, also pulse `data_ack` and clear d_seek.
    - Return to IDLE.
  - WAIT_A, on `mem_ready`: load `audio_data`, pulse `audio_ack`, clear a_pend, and return to IDLE.
- A `mem_ready` seen in IDLE is ignored.
- Only one memory read is ever outstanding.
- A `data_req` during WAIT_D sets d_pend. On return, if the fetched tag matches the current `data_addr[31:1]`, it is served and d_pend is cleared; otherwise d_pend stays set and the word is refetched.

## Timing
- All outputs are registered.
- Request sampled at edge t, block in IDLE → `mem_rd` high during cycle t+1.
- `mem_ready` sampled at edge r → `data`/`audio_data` and the ack are valid in cycle r+1. The next `mem_rd` comes no earlier than cycle r+2.
- Cache hit: `data_req` sampled at t → new `data` during cycle t+1. No `mem_rd` is issued.
- `data_ack` and `audio_ack` are exactly 1 cycle wide and never overlap a `mem_rd`.
- Simultaneous events:
  - Seek and `data_req` in the same cycle: the seek wins.
  - `audio_req` and `mem_ready` for audio in the same cycle: the ack completes and a_pend re-sets with the new address; no overrun.
- Reset mid-fetch: returns to IDLE with all flags clear, and the late `mem_ready` is ignored.
- Address wrap: `data_addr` 0xFFFF_FFFF → 0 is handled as an ordinary miss.

## Test plan
- **Seek fill.** Stimulus: raise `data_seek` with `data_addr`=0x0000_1235; memory returns 0xBEEF after 4 cycles. Required: `mem_addr`=0x091A; `data`=0xBE; one `data_ack` pulse.
- **Sequential hit/miss.** Stimulus: after the seek fill, `data_req` with `data_addr`=0x1236, then `data_req` with `data_addr`=0x1237. Required: 0x1236 causes one `mem_rd` (0x091B), with `data` = low byte of the returned word. 0x1237 causes no `mem_rd`, and `data` becomes the high byte on the next cycle.
- **Round-robin.** Stimulus: a_pend and d_pend set together with `last_grant`=DATA. Required: audio is granted first and data second; `audio_ack` precedes the data update.
- **Re-seek in flight.** Stimulus: new seek to 0x4000 while a data fetch for 0x1236 is pending. Required: the first return is discarded with no `data_ack`; then a `mem_rd` to 0x2000 is issued, followed by a single `data_ack`.
- **Overrun.** Stimulus: two `audio_req` pulses (addresses 0x10, 0x20) while a data fetch is busy. Required: one `audio_overrun` pulse; only `mem_addr`=0x10 (byte address 0x20 >> 1) is fetched; one `audio_ack`.
- **Reset mid-fetch.** Stimulus: assert `RST_N` low while in WAIT_D, then deliver a late `mem_ready`. Required: all outputs 0; no ack; `data` unchanged.
